adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake. The datapath is built from 4-bit lookahead groups and split into `STAGES` register-separated chunks, with the carry passed between them. It extends the fixed 8-bit combinational adder to arbitrary width, adds a subtract mode, and supports back-pressure. It sits between operand-issue logic and a result consumer in the ALU path.

---
 rtl/adder_pipe.sv | 182 ++++++++++++++++++
 tb/tb_adder_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define ADDER_PIPE_FLAGS_EN to build the registered ovf/zero flags; otherwise they read 0.
module adder_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned CW = WIDTH / STAGES;
   localparam int unsigned NG = CW / 4;

   // Returns carries c[0..4] of one 4-bit lookahead group.
   function automatic logic [4:0] cla4_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic c0);
      logic [4:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

   logic [STAGES-1:0] vld_q, vld_d, load;

   // A stage loads when empty or when its contents move on this cycle.
   always_comb begin
      logic nxt;
      nxt  = out_ready;
      load = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         nxt     = !vld_q[k] || nxt;
         load[k] = nxt;
      end
   end

   assign in_ready = load[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned BW = WIDTH - k * CW;

      logic             v_src, c_src;
      logic [WIDTH-1:0] sa_src;
      logic [BW-1:0]    b_src;
      logic [WIDTH-1:0] sa_q, sa_d;
      logic             c_q, c_d;
      logic [CW-1:0]    p, g, s;
      logic [CW:0]      cv;

      if (k == 0) begin : g_head
         assign v_src  = in_valid;
         assign c_src  = cin ^ sub;
         assign sa_src = in1;
         assign b_src  = in2 ^ {WIDTH{sub}};
      end else begin : g_body
         assign v_src  = vld_q[k-1];
         assign c_src  = g_stage[k-1].c_q;
         assign sa_src = g_stage[k-1].sa_q;
         assign b_src  = g_stage[k-1].g_bq.b_q;
      end

      assign p = sa_src[k*CW +: CW] ^ b_src[CW-1:0];
      assign g = sa_src[k*CW +: CW] & b_src[CW-1:0];

      // Groups ripple into each other within the chunk.
      always_comb begin
         logic [4:0] c4;
         c4    = '0;
         cv    = '0;
         cv[0] = c_src;
         for (int i = 0; i < NG; i++) begin
            c4            = cla4_carry(p[4*i +: 4], g[4*i +: 4], cv[4*i]);
            cv[4*i+1 +: 4] = c4[4:1];
         end
      end

      assign s        = p ^ cv[CW-1:0];
      assign vld_d[k] = load[k] ? v_src : vld_q[k];

      // sa carries finished sum bits below this chunk and untouched A bits above it.
      always_comb begin
         sa_d = sa_q;
         c_d  = c_q;
         if (load[k] && v_src) begin
            sa_d             = sa_src;
            sa_d[k*CW +: CW] = s;
            c_d              = cv[CW];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sa_q <= '0;
            c_q  <= 1'b0;
         end else begin
            sa_q <= sa_d;
            c_q  <= c_d;
         end
      end

      if (k < STAGES - 1) begin : g_bq
         logic [BW-CW-1:0] b_q, b_d;

         always_comb begin
            b_d = b_q;
            if (load[k] && v_src) b_d = b_src[BW-1:CW];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) b_q <= '0;
            else        b_q <= b_d;
         end
      end

`ifdef ADDER_PIPE_FLAGS_EN
      logic z_src, z_q, z_d;

      if (k == 0) begin : g_zhead
         assign z_src = 1'b1;
      end else begin : g_zbody
         assign z_src = g_stage[k-1].z_q;
      end

      always_comb begin
         z_d = z_q;
         if (load[k] && v_src) z_d = z_src & (s == '0);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) z_q <= 1'b0;
         else        z_q <= z_d;
      end

      if (k == STAGES - 1) begin : g_ovf
         logic ovf_q, ovf_d;

         always_comb begin
            ovf_d = ovf_q;
            if (load[k] && v_src) ovf_d = cv[CW] ^ cv[CW-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ovf_q <= 1'b0;
            else        ovf_q <= ovf_d;
         end
      end
`endif
   end

   assign out_valid = vld_q[STAGES-1];
   assign out       = g_stage[STAGES-1].sa_q;
   assign cout      = g_stage[STAGES-1].c_q;

`ifdef ADDER_PIPE_FLAGS_EN
   assign ovf  = g_stage[STAGES-1].g_ovf.ovf_q;
   assign zero = g_stage[STAGES-1].z_q;
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a 32-bit/2-stage instance driven by directed steps, plus
// 64-bit/1-stage and 64-bit/4-stage instances exercised with random traffic and back-pressure.
module tb_adder_pipe;

`ifdef ADDER_PIPE_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct {
      logic [63:0] res;
      logic        co;
      logic        ov;
      logic        z;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   exp_t q[3][$];
   bit   seen[3];
   bit   lat_mode;

   // Main DUT: 32 bits, 2 stages.
   logic        m_iv, m_ordy, m_sub, m_cin;
   logic [31:0] m_a, m_b, m_out;

   // Sweep DUTs: index 0 -> STAGES=1, index 1 -> STAGES=4.
   logic [1:0]  s_iv, s_ordy, s_sub, s_cin;
   logic [63:0] s_a[2], s_b[2];
   logic [63:0] s1_out, s4_out;

   logic [2:0]  o_valid, o_co, o_ovf, o_zero, i_rdy, o_ready;
   logic [63:0] o_out[3];

   assign o_out[0] = {32'h0, m_out};
   assign o_out[1] = s1_out;
   assign o_out[2] = s4_out;
   assign o_ready  = {s_ordy[1], s_ordy[0], m_ordy};

   adder_pipe #(.WIDTH(32), .STAGES(2)) u_main (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (m_iv),
      .in_ready (i_rdy[0]),
      .sub      (m_sub),
      .cin      (m_cin),
      .in1      (m_a),
      .in2      (m_b),
      .out_valid(o_valid[0]),
      .out_ready(m_ordy),
      .out      (m_out),
      .cout     (o_co[0]),
      .ovf      (o_ovf[0]),
      .zero     (o_zero[0])
   );

   adder_pipe #(.WIDTH(64), .STAGES(1)) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (s_iv[0]),
      .in_ready (i_rdy[1]),
      .sub      (s_sub[0]),
      .cin      (s_cin[0]),
      .in1      (s_a[0]),
      .in2      (s_b[0]),
      .out_valid(o_valid[1]),
      .out_ready(s_ordy[0]),
      .out      (s1_out),
      .cout     (o_co[1]),
      .ovf      (o_ovf[1]),
      .zero     (o_zero[1])
   );

   adder_pipe #(.WIDTH(64), .STAGES(4)) u_s4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (s_iv[1]),
      .in_ready (i_rdy[2]),
      .sub      (s_sub[1]),
      .cin      (s_cin[1]),
      .in1      (s_a[1]),
      .in2      (s_b[1]),
      .out_valid(o_valid[2]),
      .out_ready(s_ordy[1]),
      .out      (s4_out),
      .cout     (o_co[2]),
      .ovf      (o_ovf[2]),
      .zero     (o_zero[2])
   );

   function automatic int width_of(input int d);
      return (d == 0) ? 32 : 64;
   endfunction

   function automatic int stages_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
   endfunction

   // Reference: {cout,out} = A + (B ^ sub) + (cin ^ sub), flags from operand/result signs.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic c);
      exp_t        e;
      logic [63:0] mask, aa, bb;
      logic [64:0] sum;
      mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      aa    = a & mask;
      bb    = (b ^ {64{s}}) & mask;
      sum   = {1'b0, aa} + {1'b0, bb} + {64'd0, c ^ s};
      e.res = sum[63:0] & mask;
      e.co  = sum[w];
      e.ov  = FLAGS && (aa[w-1] == bb[w-1]) && (e.res[w-1] != aa[w-1]);
      e.z   = FLAGS && (e.res == 64'd0);
      e.acc = 0;
      return e;
   endfunction

   task automatic chk(input string tag, input int d, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed %h expected %h", tag, d, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic c);
      exp_t e;
      e     = model(width_of(d), a, b, s, c);
      e.acc = cyc;
      q[d].push_back(e);
   endtask

   // Output monitor: every valid output is compared with the queue head, stalled or not.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (rst_n && o_valid[d]) begin
            checks++;
            assert (q[d].size() != 0) else begin
               errors++;
               $error("FAIL spurious_out dut%0d observed %h expected none", d, o_out[d]);
            end
            if (q[d].size() != 0) begin
               e = q[d][0];
               chk("out", d, o_out[d], e.res);
               chk("cout", d, {63'd0, o_co[d]}, {63'd0, e.co});
               chk("ovf", d, {63'd0, o_ovf[d]}, {63'd0, e.ov});
               chk("zero", d, {63'd0, o_zero[d]}, {63'd0, e.z});
               if (!seen[d]) begin
                  seen[d] = 1'b1;
                  if (lat_mode) chk("latency", d, 64'(cyc - e.acc), 64'(stages_of(d)));
               end
               if (o_ready[d]) begin
                  void'(q[d].pop_front());
                  seen[d] = 1'b0;
               end
            end
         end
      end
   end

   // Offers one beat to the main DUT and returns just after the edge that accepts it.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic c);
      int n;
      n     = 0;
      m_iv  = 1'b1;
      m_a   = a;
      m_b   = b;
      m_sub = s;
      m_cin = c;
      @(negedge clk);
      while (!i_rdy[0] && n < 50) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         n++;
      end
      checks++;
      assert (n < 50) else begin
         errors++;
         $error("FAIL accept_timeout dut0 observed %0d expected <50", n);
      end
      push(0, {32'h0, a}, {32'h0, b}, s, c);
      @(posedge clk);
      #1;
      m_iv = 1'b0;
   endtask

   task automatic drain();
      int n;
      n      = 0;
      m_iv   = 1'b0;
      s_iv   = '0;
      m_ordy = 1'b1;
      s_ordy = '1;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int d = 0; d < 3; d++) chk("drained", d, 64'(q[d].size()), 64'd0);
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", 0, {63'd0, o_valid[0]}, 64'd0);
      chk("rst_out", 0, o_out[0], 64'd0);
      chk("rst_cout", 0, {63'd0, o_co[0]}, 64'd0);
      chk("rst_ovf", 0, {63'd0, o_ovf[0]}, 64'd0);
      chk("rst_zero", 0, {63'd0, o_zero[0]}, 64'd0);
      chk("rst_in_ready", 0, {63'd0, i_rdy[0]}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      lat_mode = 1'b1;
      m_iv = 1'b0; m_ordy = 1'b1; m_sub = 1'b0; m_cin = 1'b0; m_a = '0; m_b = '0;
      s_iv = '0; s_ordy = '1; s_sub = '0; s_cin = '0;
      s_a[0] = '0; s_a[1] = '0; s_b[0] = '0; s_b[1] = '0;

      // Reset state.
      @(negedge clk);
      chk_reset_state();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Carry across the chunk boundary, with explicit latency probe.
      send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_early", 0, {63'd0, o_valid[0]}, 64'd0);
      @(negedge clk);
      chk("lat_due", 0, {63'd0, o_valid[0]}, 64'd1);
      @(posedge clk);
      #1;

      // Back-to-back directed operations.
      send(32'd5, 32'd7, 1'b1, 1'b0);
      send(32'h1234, 32'h1234, 1'b1, 1'b0);
      send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      send(32'd10, 32'd3, 1'b1, 1'b1);
      send(32'h80000000, 32'd1, 1'b1, 1'b0);
      send(32'h12345678, 32'h0, 1'b0, 1'b1);
      drain();

      // Reset in the middle of traffic discards everything in flight.
      send(32'hAAAA5555, 32'h11111111, 1'b0, 1'b0);
      send(32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0);
      rst_n = 1'b0;
      q[0].delete();
      seen[0] = 1'b0;
      @(negedge clk);
      chk_reset_state();
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0);
      drain();

      // Back-pressure: two accepts fill the pipe, output must hold while stalled.
      lat_mode = 1'b0;
      m_ordy   = 1'b0;
      send(32'h00000001, 32'h00000002, 1'b0, 1'b0);
      send(32'h00010000, 32'h0000FFFF, 1'b0, 1'b1);
      m_iv = 1'b1; m_a = 32'h00000100; m_b = 32'h00000001; m_sub = 1'b1; m_cin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("in_ready_full", 0, {63'd0, i_rdy[0]}, 64'd0);
         @(posedge clk);
         #1;
      end
      m_ordy = 1'b1;
      send(32'h00000100, 32'h00000001, 1'b1, 1'b0);
      send(32'hFFFF0000, 32'h00010000, 1'b0, 1'b0);
      send(32'h00000000, 32'h00000001, 1'b1, 1'b0);
      send(32'h55555555, 32'h55555555, 1'b1, 1'b1);
      drain();

      // Random traffic: first unstalled (latency checked), then with random back-pressure.
      lat_mode = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (c == 150) begin
            drain();
            lat_mode = 1'b0;
         end
         m_iv   = ($urandom_range(0, 3) != 0);
         m_a    = $urandom;
         m_b    = ($urandom_range(0, 7) == 0) ? m_a : $urandom;
         m_sub  = 1'($urandom_range(0, 1));
         m_cin  = 1'($urandom_range(0, 1));
         m_ordy = lat_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
         for (int j = 0; j < 2; j++) begin
            s_iv[j]   = ($urandom_range(0, 3) != 0);
            s_a[j]    = {$urandom, $urandom};
            s_b[j]    = ($urandom_range(0, 7) == 0) ? s_a[j] : {$urandom, $urandom};
            s_sub[j]  = 1'($urandom_range(0, 1));
            s_cin[j]  = 1'($urandom_range(0, 1));
            s_ordy[j] = lat_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
         end
         @(negedge clk);
         if (m_iv && i_rdy[0]) push(0, {32'h0, m_a}, {32'h0, m_b}, m_sub, m_cin);
         for (int j = 0; j < 2; j++)
            if (s_iv[j] && i_rdy[j+1]) push(j + 1, s_a[j], s_b[j], s_sub[j], s_cin[j]);
         @(posedge clk);
         #1;
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
